// File: rtl/score_event_driver.sv
// -----------------------------------------------------------------------------
// score_event_driver
//
// Turns game events into single-cycle score pulses for the score board.
// Food and bonus awards are queued in a saturating pending counter and drained
// at one `add` pulse per cycle. A hunger timer requests one `decr` pulse every
// DECAY_PERIOD enabled cycles. Pausing freezes everything; gameover flushes it.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   enable    in   1 = game running, 0 = paused
//   eat       in   single-cycle pulse, queues FOOD_POINTS
//   bonus     in   single-cycle pulse, queues BONUS_POINTS
//   gameover  in   level from the score board, flushes all queued activity
//   add       out  registered, one cycle = score +1
//   decr      out  registered, one cycle = score -1
//   pending   out  points queued but not yet issued
//   busy      out  registered, pending work or decay request outstanding
// -----------------------------------------------------------------------------
module score_event_driver #(
    parameter int FOOD_POINTS  = 5,
    parameter int BONUS_POINTS = 20,
    parameter int DECAY_PERIOD = 100000000,
    parameter int PEND_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              eat,
    input  logic              bonus,
    input  logic              gameover,
    output logic              add,
    output logic              decr,
    output logic [PEND_W-1:0] pending,
    output logic              busy
);

    localparam int CNT_W = $clog2(DECAY_PERIOD);
    // Sum is carried with headroom so pending + any single award can never
    // wrap before the saturation clamp sees it.
    localparam int SUM_W = PEND_W + 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_PERIOD - 1);
    localparam logic [SUM_W-1:0] PEND_MAX = {{8{1'b0}}, {PEND_W{1'b1}}};

    logic [CNT_W-1:0]  decay_cnt;
    logic              decay_req;

    logic              add_next;
    logic              decr_next;
    logic [PEND_W-1:0] pending_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              req_next;
    logic              busy_next;
    logic              wrap;
    logic              take;
    logic [SUM_W-1:0]  inc;
    logic [SUM_W-1:0]  sum;

    always_comb begin
        // NOTE: every value written here gets a default first, so the paths
        // that leave a signal untouched cannot infer a latch.
        add_next     = 1'b0;
        decr_next    = 1'b0;
        pending_next = pending;
        cnt_next     = decay_cnt;
        req_next     = decay_req;
        wrap         = 1'b0;
        take         = 1'b0;
        inc          = '0;
        sum          = '0;

        if (gameover) begin
            pending_next = '0;
            cnt_next     = '0;
            req_next     = 1'b0;
        end else if (enable) begin
            if (decay_cnt == CNT_LAST) begin
                cnt_next = '0;
                wrap     = 1'b1;
            end else begin
                cnt_next = decay_cnt + CNT_W'(1);
            end

            // An outstanding request is always issued on this edge, so the
            // request flag afterwards is simply whether the timer wrapped.
            // Requests therefore never stack.
            if (decay_req) begin
                decr_next = 1'b1;
            end else begin
                take     = (pending != '0);
                add_next = take;
            end
            req_next = wrap;

            inc = (eat   ? SUM_W'(FOOD_POINTS)  : '0)
                + (bonus ? SUM_W'(BONUS_POINTS) : '0);
            // take implies pending >= 1, so the subtraction cannot underflow.
            sum = SUM_W'(pending) + inc - SUM_W'(take);
            pending_next = (sum > PEND_MAX) ? {PEND_W{1'b1}} : sum[PEND_W-1:0];
        end

        busy_next = (pending_next != '0) || req_next;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            add       <= 1'b0;
            decr      <= 1'b0;
            pending   <= '0;
            busy      <= 1'b0;
            decay_cnt <= '0;
            decay_req <= 1'b0;
        end else begin
            add       <= add_next;
            decr      <= decr_next;
            pending   <= pending_next;
            busy      <= busy_next;
            decay_cnt <= cnt_next;
            decay_req <= req_next;
        end
    end

endmodule

// File: tb/tb_score_event_driver.sv
// -----------------------------------------------------------------------------
// tb_score_event_driver
//
// Directed bench for score_event_driver. Three instances share the inputs:
//   u_a  DECAY_PERIOD=10,   PEND_W=8  (decay, pause, gameover scenarios)
//   u_b  DECAY_PERIOD=1000, PEND_W=8  (food/bonus draining)
//   u_c  DECAY_PERIOD=1000, PEND_W=4  (saturation)
// Edge numbering: edge 1 is the first rising edge after reset is released;
// outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_score_event_driver;

    logic clk = 1'b0;
    logic reset, enable, eat, bonus, gameover;

    logic       a_add, a_decr, a_busy;
    logic [7:0] a_pending;
    logic       b_add, b_decr, b_busy;
    logic [7:0] b_pending;
    logic       c_add, c_decr, c_busy;
    logic [3:0] c_pending;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    score_event_driver #(.FOOD_POINTS(5), .BONUS_POINTS(20), .DECAY_PERIOD(10), .PEND_W(8)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .eat(eat), .bonus(bonus), .gameover(gameover),
        .add(a_add), .decr(a_decr), .pending(a_pending), .busy(a_busy)
    );

    score_event_driver #(.FOOD_POINTS(5), .BONUS_POINTS(20), .DECAY_PERIOD(1000), .PEND_W(8)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .eat(eat), .bonus(bonus), .gameover(gameover),
        .add(b_add), .decr(b_decr), .pending(b_pending), .busy(b_busy)
    );

    score_event_driver #(.FOOD_POINTS(5), .BONUS_POINTS(20), .DECAY_PERIOD(1000), .PEND_W(4)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .eat(eat), .bonus(bonus), .gameover(gameover),
        .add(c_add), .decr(c_decr), .pending(c_pending), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b1;
        eat      = 1'b0;
        bonus    = 1'b0;
        gameover = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset must win even with events asserted.
    task automatic test_reset();
        logic [10:0] obs;
        reset    = 1'b1;
        enable   = 1'b1;
        eat      = 1'b1;
        bonus    = 1'b1;
        gameover = 1'b0;
        repeat (3) tick();
        obs = {a_add, a_decr, a_busy, a_pending};
        n_checks++; if (obs !== 11'd0) $display("FAIL reset_a: got %h want 000", obs); else n_pass++;
        obs = {b_add, b_decr, b_busy, b_pending};
        n_checks++; if (obs !== 11'd0) $display("FAIL reset_b: got %h want 000", obs); else n_pass++;
        obs = {4'd0, c_add, c_decr, c_busy, c_pending};
        n_checks++; if (obs !== 11'd0) $display("FAIL reset_c: got %h want 000", obs); else n_pass++;
        eat   = 1'b0;
        bonus = 1'b0;
    endtask

    // Idle with period 10: request set on edge 10, issued on edge 11, etc.
    task automatic test_idle_decay();
        logic want_d, want_b;
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            tick();
            want_d = (k == 11) || (k == 21) || (k == 31);
            want_b = (k == 10) || (k == 20) || (k == 30);
            n_checks++; if (a_decr !== want_d) $display("FAIL idle_decr edge %0d: got %b want %b", k, a_decr, want_d); else n_pass++;
            n_checks++; if (a_busy !== want_b) $display("FAIL idle_busy edge %0d: got %b want %b", k, a_busy, want_b); else n_pass++;
            n_checks++; if (a_add !== 1'b0) $display("FAIL idle_add edge %0d: got %b want 0", k, a_add); else n_pass++;
            n_checks++; if (a_pending !== 8'd0) $display("FAIL idle_pending edge %0d: got %0d want 0", k, a_pending); else n_pass++;
        end
    endtask

    // eat on edge 3 -> pending 5, adds on edges 4..8.
    task automatic test_single_eat();
        logic [7:0] want_p;
        logic       want_a, want_b;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            eat = (k == 3);
            tick();
            want_p = (k >= 3 && k <= 8) ? 8'(8 - k) : 8'd0;
            want_a = (k >= 4 && k <= 8);
            want_b = (k >= 3 && k <= 7);
            n_checks++; if (b_pending !== want_p) $display("FAIL eat_pending edge %0d: got %0d want %0d", k, b_pending, want_p); else n_pass++;
            n_checks++; if (b_add !== want_a) $display("FAIL eat_add edge %0d: got %b want %b", k, b_add, want_a); else n_pass++;
            n_checks++; if (b_busy !== want_b) $display("FAIL eat_busy edge %0d: got %b want %b", k, b_busy, want_b); else n_pass++;
        end
        eat = 1'b0;
    endtask

    // eat+bonus together -> 25 back-to-back adds.
    task automatic test_eat_bonus();
        int n_add = 0;
        logic want_a;
        do_reset();
        eat   = 1'b1;
        bonus = 1'b1;
        tick();
        eat   = 1'b0;
        bonus = 1'b0;
        n_checks++; if (b_pending !== 8'd25) $display("FAIL sum_pending: got %0d want 25", b_pending); else n_pass++;
        for (int k = 2; k <= 31; k++) begin
            tick();
            want_a = (k <= 26);
            if (b_add === 1'b1) n_add++;
            n_checks++; if (b_add !== want_a) $display("FAIL sum_add edge %0d: got %b want %b", k, b_add, want_a); else n_pass++;
        end
        n_checks++; if (n_add != 25) $display("FAIL sum_count: got %0d want 25", n_add); else n_pass++;
        n_checks++; if (b_pending !== 8'd0) $display("FAIL sum_drained: got %0d want 0", b_pending); else n_pass++;
    endtask

    // PEND_W=4, eat every cycle: 5, 9, 13, then clamp at 15.
    task automatic test_saturation();
        logic [3:0] want_p [8] = '{4'd5, 4'd9, 4'd13, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        do_reset();
        eat = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (c_pending !== want_p[k]) $display("FAIL sat_pending edge %0d: got %0d want %0d", k + 1, c_pending, want_p[k]); else n_pass++;
        end
        eat = 1'b0;
        n_checks++; if (c_busy !== 1'b1) $display("FAIL sat_busy: got %b want 1", c_busy); else n_pass++;
    endtask

    // eat on edge 8 leaves pending=3 when the edge-10 request is issued on edge 11.
    task automatic test_decay_with_pending();
        logic       want_a [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       want_d [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] want_p [11] = '{8'd5, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        int n_add = 0;
        int n_decr = 0;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            eat = (k == 8);
            tick();
            if (k >= 8) begin
                n_checks++; if (a_add !== want_a[k-8]) $display("FAIL dp_add edge %0d: got %b want %b", k, a_add, want_a[k-8]); else n_pass++;
                n_checks++; if (a_decr !== want_d[k-8]) $display("FAIL dp_decr edge %0d: got %b want %b", k, a_decr, want_d[k-8]); else n_pass++;
                n_checks++; if (a_pending !== want_p[k-8]) $display("FAIL dp_pending edge %0d: got %0d want %0d", k, a_pending, want_p[k-8]); else n_pass++;
            end
            if (k >= 11 && a_add === 1'b1) n_add++;
            if (k >= 11 && a_decr === 1'b1) n_decr++;
        end
        eat = 1'b0;
        n_checks++; if (n_add != 3) $display("FAIL dp_add_count: got %0d want 3", n_add); else n_pass++;
        n_checks++; if (n_decr != 1) $display("FAIL dp_decr_count: got %0d want 1", n_decr); else n_pass++;
    endtask

    // Pause edges 3..7 with pending=4; eat on edge 4 is dropped; the timer
    // resumes from 2, so the request lands on edge 15 and decr on edge 16.
    task automatic test_pause();
        logic [7:0] want_p;
        logic       want_a, want_d;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            enable = !(k >= 3 && k <= 7);
            eat    = (k == 1) || (k == 4);
            tick();
            want_p = (k == 1) ? 8'd5 : (k <= 7) ? 8'd4 : (k <= 11) ? 8'(11 - k) : 8'd0;
            want_a = (k == 2) || (k >= 8 && k <= 11);
            want_d = (k == 16);
            n_checks++; if (a_pending !== want_p) $display("FAIL pause_pending edge %0d: got %0d want %0d", k, a_pending, want_p); else n_pass++;
            n_checks++; if (a_add !== want_a) $display("FAIL pause_add edge %0d: got %b want %b", k, a_add, want_a); else n_pass++;
            n_checks++; if (a_decr !== want_d) $display("FAIL pause_decr edge %0d: got %b want %b", k, a_decr, want_d); else n_pass++;
        end
        eat    = 1'b0;
        enable = 1'b1;
    endtask

    // Eats on edges 7 and 9 give pending=7 after edge 10, the same edge that
    // raises the decay request; gameover on edge 11 must flush both.
    task automatic test_gameover();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            eat = (k == 7) || (k == 9);
            tick();
        end
        n_checks++; if (a_pending !== 8'd7) $display("FAIL go_setup_pending: got %0d want 7", a_pending); else n_pass++;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL go_setup_busy: got %b want 1", a_busy); else n_pass++;

        gameover = 1'b1;
        eat      = 1'b1;
        tick();
        n_checks++; if (a_pending !== 8'd0) $display("FAIL go_pending: got %0d want 0", a_pending); else n_pass++;
        n_checks++; if (a_add !== 1'b0) $display("FAIL go_add: got %b want 0", a_add); else n_pass++;
        n_checks++; if (a_decr !== 1'b0) $display("FAIL go_decr: got %b want 0", a_decr); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL go_busy: got %b want 0", a_busy); else n_pass++;
        tick();
        eat = 1'b0;
        n_checks++; if (a_pending !== 8'd0) $display("FAIL go_eat_ignored: got %0d want 0", a_pending); else n_pass++;
        n_checks++; if (a_add !== 1'b0) $display("FAIL go_add_held: got %b want 0", a_add); else n_pass++;

        do_reset();
        eat = 1'b1;
        tick();
        eat = 1'b0;
        n_checks++; if (a_pending !== 8'd5) $display("FAIL go_resume_pending: got %0d want 5", a_pending); else n_pass++;
        tick();
        n_checks++; if (a_add !== 1'b1) $display("FAIL go_resume_add: got %b want 1", a_add); else n_pass++;
        n_checks++; if (a_pending !== 8'd4) $display("FAIL go_resume_drain: got %0d want 4", a_pending); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_decay();
        test_single_eat();
        test_eat_bonus();
        test_saturation();
        test_decay_with_pending();
        test_pause();
        test_gameover();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
